eeprom_rw_checker: RTL and testbench
====================================

Name: eeprom_rw_checker

Overview:
- Self-test sequencer for the I2C EEPROM path.
- Writes a known byte pattern through the I2C byte-transaction engine, reads it back, and compares it.
- Produces the rw_done / rw_result status consumed by the LED alarm block.
- Sits between a start trigger (key or power-up pulse) and the I2C master engine; it is the producer of the status that the alarm displays.

Parameters:
- NUM_BYTES, 8: number of bytes written then read back; legal range 1..256.
- BASE_ADDR, 16'h0000: first EEPROM word address; byte i uses (BASE_ADDR+i) mod 2^16.
- DATA_SEED, 8'hA5: pattern base; byte i data = (DATA_SEED+i) mod 256.
- WAIT_CYCLES, 250_000: EEPROM internal write-cycle gap after each write (5 ms at 50 MHz); legal range ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle request to run the test; sampled only in IDLE or DONE.
- i2c_busy  input  1  engine busy; a request may only be issued while low.
- i2c_done  input  1  one-cycle pulse, transaction finished.
- i2c_nack  input  1  valid with i2c_done; 1 = slave did not acknowledge.
- i2c_rdata  input  8  read byte, valid with i2c_done of a read.
- i2c_req  output  1  one-cycle transaction request.
- i2c_rw  output  1  0 = write, 1 = read; stable from i2c_req until i2c_done.
- i2c_addr  output  16  word address; stable from i2c_req until i2c_done.
- i2c_wdata  output  8  write data; stable from i2c_req until i2c_done.
- rw_done  output  1  level; high while the test is finished, until the next start.
- rw_result  output  1  valid while rw_done=1; 1 = all bytes matched and no NACK.
- err_cnt  output  8  number of mismatched read bytes; saturates at 255.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte index 0, delay counter 0.
- All outputs are registered.
- States:
  - IDLE: start=1 → WR_REQ; index cleared; err_cnt cleared.
  - WR_REQ: while i2c_busy=1, wait. When i2c_busy=0: i2c_req=1 for exactly one cycle, with i2c_rw=0, addr=BASE_ADDR+idx, wdata=DATA_SEED+idx. Next state WR_WAIT.
  - WR_WAIT: wait for i2c_done.
    - i2c_nack=1 → DONE with rw_result=0.
    - Otherwise → WR_DELAY; counter loaded to 0.
  - WR_DELAY: count up to WAIT_CYCLES-1 (exactly WAIT_CYCLES cycles spent in this state).
    - If idx<NUM_BYTES-1: idx+1, → WR_REQ.
    - Else: idx=0, → RD_REQ.
  - RD_REQ: same as WR_REQ but i2c_rw=1; wdata is don't-care and is driven 0. Next state RD_WAIT.
  - RD_WAIT: on i2c_done:
    - i2c_nack=1 → DONE with rw_result=0.
    - If i2c_rdata != DATA_SEED+idx: err_cnt+1 (saturating).
    - If idx<NUM_BYTES-1: idx+1, → RD_REQ. Else → DONE.
  - A mismatch does not abort; all reads complete.
  - DONE: rw_done=1 from the cycle of entry.
    - rw_result=1 iff no NACK occurred and err_cnt==0 after the final compare, including the last byte.
    - start=1 → IDLE-equivalent restart: go directly to WR_REQ next cycle; rw_done, rw_result and err_cnt clear in that same transition.
- Latency:
  - start→i2c_req: 2 cycles when i2c_busy=0 (IDLE→WR_REQ, req asserted in WR_REQ).
  - i2c_done→next i2c_req: WAIT_CYCLES+1 cycles after a write; 1 cycle after a read.
- Start outside IDLE/DONE is ignored.
- i2c_done outside WR_WAIT/RD_WAIT is ignored.
- The engine never asserts i2c_done in the same cycle as i2c_req; if it does, the done is ignored.
- Address arithmetic wraps at 16 bits; data arithmetic wraps at 8 bits. idx is wide enough for NUM_BYTES-1.
- Reset mid-operation: immediate return to reset values; i2c_req drops asynchronously. No partial status is retained.

Test Plan:
1. NUM_BYTES=4, WAIT_CYCLES=10, model echoes written data → writes A5,A6,A7,A8 at 0..3, then 4 reads; rw_done=1, rw_result=1, err_cnt=0; the gap between write done and next req is 11 cycles.
2. Same setup, model corrupts byte 2 to 8'h00 → all 4 reads occur; rw_done=1, rw_result=0, err_cnt=1.
3. NACK on the second write → no further i2c_req; DONE within 1 cycle; rw_result=0; no read issued.
4. BASE_ADDR=16'hFFFE, NUM_BYTES=4, DATA_SEED=8'hFE → addresses FFFE,FFFF,0000,0001 with data FE,FF,00,01; pass.
5. Hold i2c_busy=1 for 50 cycles after start → i2c_req held off, then exactly one pulse; start pulsed mid-test is ignored.
6. Assert rst_n=0 during WR_DELAY, release, then start → all outputs 0 during reset; a fresh full run passes with err_cnt=0; a second start from DONE clears rw_done in 1 cycle.

Source files
------------

// File: rtl/eeprom_rw_checker.sv
// eeprom_rw_checker
// Self-test sequencer for the I2C EEPROM path. On start it writes NUM_BYTES
// bytes (data DATA_SEED+i at word address BASE_ADDR+i) through the I2C
// byte-transaction engine, waiting WAIT_CYCLES after each write for the
// EEPROM internal write cycle. It then reads every byte back and compares it.
// The pass/fail status is held on rw_done/rw_result for the LED alarm block.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             one-cycle run request (honoured only in IDLE or DONE)
//   i2c_busy          engine busy; requests are held off while high
//   i2c_done          one-cycle transaction-finished pulse from the engine
//   i2c_nack          slave did not acknowledge (valid with i2c_done)
//   i2c_rdata         read byte (valid with i2c_done of a read)
//   i2c_req           one-cycle transaction request to the engine
//   i2c_rw            0 = write, 1 = read (held until i2c_done)
//   i2c_addr          16-bit EEPROM word address (held until i2c_done)
//   i2c_wdata         write data, 0 for reads (held until i2c_done)
//   rw_done           high while the test is finished, until the next start
//   rw_result         1 = all bytes matched and no NACK (valid with rw_done)
//   err_cnt           mismatched read bytes, saturating at 255
module eeprom_rw_checker #(
  parameter int unsigned NUM_BYTES   = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [7:0]  DATA_SEED   = 8'hA5,
  parameter int unsigned WAIT_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [7:0]  i2c_rdata,
  output logic        i2c_req,
  output logic        i2c_rw,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_wdata,
  output logic        rw_done,
  output logic        rw_result,
  output logic [7:0]  err_cnt
);

  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_WAIT,
    S_WR_DELAY,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             rw_q, rw_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             result_q, result_d;
  logic [7:0]       err_q, err_d;

  logic             done_ok;
  logic [7:0]       exp_data;
  logic [7:0]       err_after;

  // A done coinciding with our own request cannot belong to it; drop it.
  assign done_ok   = i2c_done && !req_q;
  assign exp_data  = DATA_SEED + 8'(idx_q);
  // Error count including the byte being compared this cycle (saturating).
  assign err_after = (i2c_rdata != exp_data && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    req_d    = 1'b0;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR_REQ;
          idx_d   = '0;
          err_d   = 8'd0;
        end
      end

      S_WR_REQ: begin
        if (!i2c_busy) begin
          req_d   = 1'b1;
          rw_d    = 1'b0;
          addr_d  = BASE_ADDR + 16'(idx_q);
          wdata_d = exp_data;
          state_d = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (done_ok) begin
          if (i2c_nack) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = 1'b0;
          end else begin
            state_d = S_WR_DELAY;
            cnt_d   = '0;
          end
        end
      end

      // EEPROM internal write cycle: WAIT_CYCLES cycles spent here.
      S_WR_DELAY: begin
        if (cnt_q == LAST_CNT) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_RD_REQ;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_WR_REQ;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RD_REQ: begin
        if (!i2c_busy) begin
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = BASE_ADDR + 16'(idx_q);
          wdata_d = 8'h00;
          state_d = S_RD_WAIT;
        end
      end

      // A mismatch is counted but never aborts; only a NACK ends early.
      S_RD_WAIT: begin
        if (done_ok) begin
          if (i2c_nack) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = 1'b0;
          end else begin
            err_d = err_after;
            if (idx_q == LAST_IDX) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = (err_after == 8'd0);
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_RD_REQ;
            end
          end
        end
      end

      // Restart straight from DONE, clearing status in the same transition.
      S_DONE: begin
        if (start) begin
          state_d  = S_WR_REQ;
          idx_d    = '0;
          err_d    = 8'd0;
          done_d   = 1'b0;
          result_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      err_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign i2c_req   = req_q;
  assign i2c_rw    = rw_q;
  assign i2c_addr  = addr_q;
  assign i2c_wdata = wdata_q;
  assign rw_done   = done_q;
  assign rw_result = result_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_eeprom_rw_checker.sv
// tb_eeprom_rw_checker
// Directed bench for eeprom_rw_checker. Two instances share one engine model:
// dut A (base 0000, seed A5) and dut B (base FFFE, seed FE), both with
// NUM_BYTES=4 and WAIT_CYCLES=10. The engine model answers each request three
// cycles later, stores writes in a small memory, and can inject a NACK on a
// chosen write or corrupt a chosen read address on dut A.
module tb_eeprom_rw_checker;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_v [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       nack_v  [2];
  logic [7:0] rdata_v [2];

  logic        req_a, rw_a, rwd_a, res_a;
  logic [15:0] addr_a;
  logic [7:0]  wd_a, err_a;
  logic        req_b, rw_b, rwd_b, res_b;
  logic [15:0] addr_b;
  logic [7:0]  wd_b, err_b;

  eeprom_rw_checker #(
    .NUM_BYTES(4), .BASE_ADDR(16'h0000), .DATA_SEED(8'hA5), .WAIT_CYCLES(W)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .i2c_busy(busy_v[0]), .i2c_done(done_v[0]), .i2c_nack(nack_v[0]),
    .i2c_rdata(rdata_v[0]), .i2c_req(req_a), .i2c_rw(rw_a),
    .i2c_addr(addr_a), .i2c_wdata(wd_a), .rw_done(rwd_a),
    .rw_result(res_a), .err_cnt(err_a)
  );

  eeprom_rw_checker #(
    .NUM_BYTES(4), .BASE_ADDR(16'hFFFE), .DATA_SEED(8'hFE), .WAIT_CYCLES(W)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .i2c_busy(busy_v[1]), .i2c_done(done_v[1]), .i2c_nack(nack_v[1]),
    .i2c_rdata(rdata_v[1]), .i2c_req(req_b), .i2c_rw(rw_b),
    .i2c_addr(addr_b), .i2c_wdata(wd_b), .rw_done(rwd_b),
    .rw_result(res_b), .err_cnt(err_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Engine model state and transaction log.
  int          pend [2];
  logic        pnack [2];
  logic [7:0]  prdata [2];
  logic [7:0]  mem [2][256];
  int          nreq [2];
  int          nwr [2];
  int          ndone [2];
  logic        lrw [2][16];
  logic [15:0] laddr [2][16];
  logic [7:0]  lwd [2][16];
  int          lcyc [2][16];
  int          ldone [2][16];
  int          nack_wr_num = 0;
  int          corrupt_addr = -1;
  logic        hold_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus and checks happen 1 time unit after the falling edge, so they
  // never race the engine model, which runs exactly on the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log(input int k);
    nreq[k]  = 0;
    nwr[k]   = 0;
    ndone[k] = 0;
  endtask

  task automatic pulse_start(input int k, output int s);
    start_v[k] = 1'b1;
    s = cyc;
    step();
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int seen);
    logic d;
    seen = -1;
    for (int i = 0; i < budget && seen < 0; i++) begin
      step();
      d = (k == 0) ? rwd_a : rwd_b;
      if (d) seen = cyc;
    end
    check_eq($sformatf("dut%0d_rw_done", k), (k == 0) ? rwd_a : rwd_b, 1);
  endtask

  // Engine model: responds three cycles after each request.
  initial begin
    logic        r, rwx;
    logic [15:0] ax;
    logic [7:0]  wx;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; pnack[k] = 1'b0; prdata[k] = 8'h00;
      nreq[k] = 0; nwr[k] = 0; ndone[k] = 0;
      busy_v[k] = 1'b0; done_v[k] = 1'b0; nack_v[k] = 1'b0; rdata_v[k] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        r   = (k == 0) ? req_a  : req_b;
        rwx = (k == 0) ? rw_a   : rw_b;
        ax  = (k == 0) ? addr_a : addr_b;
        wx  = (k == 0) ? wd_a   : wd_b;
        done_v[k] = 1'b0;
        nack_v[k] = 1'b0;
        if (!rst_n) begin
          pend[k] = 0;
        end else if (pend[k] > 0) begin
          pend[k]--;
          if (pend[k] == 0) begin
            done_v[k]  = 1'b1;
            nack_v[k]  = pnack[k];
            rdata_v[k] = prdata[k];
            if (ndone[k] < 16) ldone[k][ndone[k]] = cyc;
            ndone[k]++;
          end
        end
        if (r && rst_n) begin
          $display("txn dut=%0d n=%0d rw=%0d addr=%04h wdata=%02h cyc=%0d",
                   k, nreq[k], rwx, ax, wx, cyc);
          if (nreq[k] < 16) begin
            lrw[k][nreq[k]]   = rwx;
            laddr[k][nreq[k]] = ax;
            lwd[k][nreq[k]]   = wx;
            lcyc[k][nreq[k]]  = cyc;
          end
          nreq[k]++;
          pnack[k]  = 1'b0;
          prdata[k] = 8'h00;
          if (!rwx) begin
            nwr[k]++;
            mem[k][ax[7:0]] = wx;
            if (k == 0 && nwr[k] == nack_wr_num) pnack[k] = 1'b1;
          end else begin
            prdata[k] = mem[k][ax[7:0]];
            if (k == 0 && int'(ax) == corrupt_addr) prdata[k] = 8'h00;
          end
          pend[k] = 3;
        end
        busy_v[k] = ((k == 0) && hold_busy) || (pend[k] > 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Hand-computed expectations.
  logic [15:0] exp_addr_b [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [7:0]  exp_data_b [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0]  exp_data_a [4] = '{8'hA5, 8'hA6, 8'hA7, 8'hA8};

  initial begin
    int s, seen, r;
    rst_n = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    step();
    step();
    // Reset state
    check_eq("reset_outs_a", {req_a, rw_a, addr_a, wd_a, rwd_a, res_a, err_a}, 0);
    check_eq("reset_outs_b", {req_b, rw_b, addr_b, wd_b, rwd_b, res_b, err_b}, 0);
    rst_n = 1'b1;
    step();

    // 1: clean run, echo model
    clear_log(0);
    pulse_start(0, s);
    wait_done(0, 400, seen);
    check_eq("t1_nreq", nreq[0], 8);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t1_wr%0d_rw", i), lrw[0][i], 0);
      check_eq($sformatf("t1_wr%0d_addr", i), laddr[0][i], i);
      check_eq($sformatf("t1_wr%0d_data", i), lwd[0][i], exp_data_a[i]);
      check_eq($sformatf("t1_rd%0d_rw", i), lrw[0][i+4], 1);
      check_eq($sformatf("t1_rd%0d_addr", i), laddr[0][i+4], i);
      check_eq($sformatf("t1_rd%0d_wdata", i), lwd[0][i+4], 0);
    end
    check_eq("t1_start_to_req", lcyc[0][0] - s, 2);
    check_eq("t1_wr_gap", lcyc[0][1] - ldone[0][0] - 1, W + 1);
    check_eq("t1_wr_to_rd_gap", lcyc[0][4] - ldone[0][3] - 1, W + 1);
    check_eq("t1_rd_gap", lcyc[0][5] - ldone[0][4] - 1, 1);
    check_eq("t1_result", res_a, 1);
    check_eq("t1_err_cnt", err_a, 0);

    // 2: byte 2 read back corrupted to 00
    clear_log(0);
    corrupt_addr = 2;
    pulse_start(0, s);
    check_eq("t2_restart_clears_done", rwd_a, 0);
    wait_done(0, 400, seen);
    check_eq("t2_nreq", nreq[0], 8);
    check_eq("t2_result", res_a, 0);
    check_eq("t2_err_cnt", err_a, 1);
    corrupt_addr = -1;

    // 3: NACK on the second write
    clear_log(0);
    nack_wr_num = 2;
    pulse_start(0, s);
    wait_done(0, 400, seen);
    check_eq("t3_done_latency", seen - ldone[0][1], 1);
    repeat (20) step();
    check_eq("t3_nreq", nreq[0], 2);
    check_eq("t3_result", res_a, 0);
    check_eq("t3_err_cnt", err_a, 0);
    nack_wr_num = 0;

    // 5: engine busy for 50 cycles after start, mid-test start ignored
    clear_log(0);
    hold_busy = 1'b1;
    busy_v[0] = 1'b1;
    pulse_start(0, s);
    repeat (49) step();
    check_eq("t5_held_off", nreq[0], 0);
    hold_busy = 1'b0;
    busy_v[0] = 1'b0;
    r = cyc;
    repeat (20) step();
    pulse_start(0, s);
    wait_done(0, 400, seen);
    check_eq("t5_first_req", lcyc[0][0] - r, 1);
    check_eq("t5_nreq", nreq[0], 8);
    check_eq("t5_result", res_a, 1);
    check_eq("t5_err_cnt", err_a, 0);

    // 4: address/data wrap on dut B
    clear_log(1);
    pulse_start(1, s);
    wait_done(1, 400, seen);
    check_eq("t4_nreq", nreq[1], 8);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t4_wr%0d_addr", i), laddr[1][i], exp_addr_b[i]);
      check_eq($sformatf("t4_wr%0d_data", i), lwd[1][i], exp_data_b[i]);
      check_eq($sformatf("t4_rd%0d_addr", i), laddr[1][i+4], exp_addr_b[i]);
    end
    check_eq("t4_result", res_b, 1);
    check_eq("t4_err_cnt", err_b, 0);

    // 6: reset during WR_DELAY, then fresh run and restart
    clear_log(0);
    pulse_start(0, s);
    for (int i = 0; i < 100 && ndone[0] < 1; i++) step();
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_reset_req", req_a, 0);
    check_eq("t6_reset_outs", {req_a, rw_a, addr_a, wd_a, rwd_a, res_a, err_a}, 0);
    step();
    check_eq("t6_reset_held", {req_a, rw_a, addr_a, wd_a, rwd_a, res_a, err_a}, 0);
    rst_n = 1'b1;
    step();
    clear_log(0);
    pulse_start(0, s);
    wait_done(0, 400, seen);
    check_eq("t6_nreq", nreq[0], 8);
    check_eq("t6_result", res_a, 1);
    check_eq("t6_err_cnt", err_a, 0);
    pulse_start(0, s);
    check_eq("t6_restart_clears_done", rwd_a, 0);
    check_eq("t6_restart_clears_result", res_a, 0);
    wait_done(0, 400, seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
